// File: rtl/core_types_pkg.sv
// Core-wide widths, depths and shared bundle types.
// ROB kill bundle shared by flush-aware queues.
package core_types_pkg;

  localparam int MDPT_INFO_WIDTH = 8;
  localparam int LOG_ROB_ENTRIES = 6;

  localparam int SSU_FUNNEL_BUFFER_ENTRIES = 4;
  localparam int MDP_UPDATE_Q_ENTRIES = 4;

  typedef struct packed {
    logic                       valid;
    logic [LOG_ROB_ENTRIES-1:0] abs_head_index;
    logic [LOG_ROB_ENTRIES-1:0] rel_kill_younger_index;
  } rob_kill_t;

endpackage

// File: rtl/rob_rel_kill_check.sv
// Flush check for one ROB index.
// Relative age from head, wrapped in ROB index width.
module rob_rel_kill_check
  import core_types_pkg::*;
(
  input  logic [LOG_ROB_ENTRIES-1:0] index,
  input  rob_kill_t                  kill,
  output logic                       killed
);

  logic [LOG_ROB_ENTRIES-1:0] rel;

  // younger-than-kill-point test
  always_comb begin
    rel    = index - kill.abs_head_index;
    killed = kill.valid &
             (rel >= kill.rel_kill_younger_index);
  end

endmodule

// File: rtl/ssu_rob_mdp_update_q.sv
// ssu -> ROB mdp update buffer.
// Compacting queue with merge, flush kill and drop-on-full.
module ssu_rob_mdp_update_q #(
  parameter int MDP_UPDATE_Q_ENTRIES =
    core_types_pkg::MDP_UPDATE_Q_ENTRIES,
  parameter int MDPT_INFO_WIDTH =
    core_types_pkg::MDPT_INFO_WIDTH,
  parameter int LOG_ROB_ENTRIES =
    core_types_pkg::LOG_ROB_ENTRIES
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       rob_mdp_update_valid,
  input  logic [MDPT_INFO_WIDTH-1:0] rob_mdp_update_mdp_info,
  input  logic [LOG_ROB_ENTRIES-1:0] rob_mdp_update_ROB_index,
  input  logic                       rob_kill_valid,
  input  logic [LOG_ROB_ENTRIES-1:0] rob_kill_abs_head_index,
  input  logic [LOG_ROB_ENTRIES-1:0] rob_kill_rel_kill_younger_index,
  output logic                       rob_mdp_write_valid,
  output logic [MDPT_INFO_WIDTH-1:0] rob_mdp_write_mdp_info,
  output logic [LOG_ROB_ENTRIES-1:0] rob_mdp_write_ROB_index,
  input  logic                       rob_mdp_write_ready,
  output logic                       mdp_update_drop,
  output logic [$clog2(MDP_UPDATE_Q_ENTRIES+1)-1:0]
                                     mdp_update_q_count
);

  import core_types_pkg::*;

  localparam int N  = MDP_UPDATE_Q_ENTRIES;
  localparam int IW = MDPT_INFO_WIDTH;
  localparam int RW = LOG_ROB_ENTRIES;
  localparam int CW = $clog2(N+1);

  logic [N-1:0]  v_q;
  logic [IW-1:0] info_q [N];
  logic [RW-1:0] idx_q  [N];
  logic          drop_q;
  logic [CW-1:0] cnt_q;

  logic [N-1:0]  v_d;
  logic [IW-1:0] info_d [N];
  logic [RW-1:0] idx_d  [N];
  logic          drop_d;
  logic [CW-1:0] cnt_d;

  rob_kill_t     kill;
  logic [N-1:0]  slot_kill;
  logic          in_kill;

  logic          deq;
  logic [N-1:0]  keep;
  logic [CW-1:0] pre [N];
  logic [CW-1:0] surv_cnt;
  logic [N-1:0]  hit;
  logic          in_live;
  logic          append;

  assign kill = '{
    valid:                  rob_kill_valid,
    abs_head_index:         rob_kill_abs_head_index,
    rel_kill_younger_index: rob_kill_rel_kill_younger_index
  };

  for (genvar g = 0; g < N; g++) begin : g_slot_kill
    rob_rel_kill_check u_chk (
      .index  (idx_q[g]),
      .kill   (kill),
      .killed (slot_kill[g])
    );
  end

  rob_rel_kill_check u_in_chk (
    .index  (rob_mdp_update_ROB_index),
    .kill   (kill),
    .killed (in_kill)
  );

  // removal mask and per-slot prefix count of survivors
  always_comb begin
    deq      = v_q[0] & rob_mdp_write_ready;
    keep     = v_q & ~slot_kill;
    keep[0]  = keep[0] & ~deq;
    surv_cnt = '0;
    for (int i = 0; i < N; i++) begin
      pre[i]   = surv_cnt;
      surv_cnt = surv_cnt + CW'(keep[i]);
    end
  end

  // compaction, then merge or append of the incoming update
  always_comb begin
    for (int j = 0; j < N; j++) begin
      v_d[j]    = 1'b0;
      info_d[j] = '0;
      idx_d[j]  = '0;
      for (int i = 0; i < N; i++) begin
        if (keep[i] && pre[i] == CW'(j)) begin
          v_d[j]    = 1'b1;
          info_d[j] = info_q[i];
          idx_d[j]  = idx_q[i];
        end
      end
    end
    in_live = rob_mdp_update_valid & ~in_kill;
    for (int j = 0; j < N; j++) begin
      hit[j] = v_d[j] &
               (idx_d[j] == rob_mdp_update_ROB_index);
    end
    append = in_live & ~(|hit) &
             (surv_cnt < CW'(N));
    drop_d = in_live & ~(|hit) &
             (surv_cnt == CW'(N));
    for (int j = 0; j < N; j++) begin
      if (in_live && hit[j]) begin
        info_d[j] = rob_mdp_update_mdp_info;
      end
      if (append && surv_cnt == CW'(j)) begin
        v_d[j]    = 1'b1;
        info_d[j] = rob_mdp_update_mdp_info;
        idx_d[j]  = rob_mdp_update_ROB_index;
      end
    end
    cnt_d = surv_cnt + CW'(append);
  end

  // queue state registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      v_q    <= '0;
      drop_q <= 1'b0;
      cnt_q  <= '0;
      for (int j = 0; j < N; j++) begin
        info_q[j] <= '0;
        idx_q[j]  <= '0;
      end
    end else begin
      v_q    <= v_d;
      drop_q <= drop_d;
      cnt_q  <= cnt_d;
      for (int j = 0; j < N; j++) begin
        info_q[j] <= info_d[j];
        idx_q[j]  <= idx_d[j];
      end
    end
  end

  assign rob_mdp_write_valid     = v_q[0];
  assign rob_mdp_write_mdp_info  = info_q[0];
  assign rob_mdp_write_ROB_index = idx_q[0];
  assign mdp_update_drop         = drop_q;
  assign mdp_update_q_count      = cnt_q;

endmodule

// File: tb/tb_ssu_rob_mdp_update_q.sv
// Bench for ssu_rob_mdp_update_q.
// Directed cases plus random traffic against a queue model.
module tb_ssu_rob_mdp_update_q;
  import core_types_pkg::*;

  localparam int N  = MDP_UPDATE_Q_ENTRIES;
  localparam int IW = MDPT_INFO_WIDTH;
  localparam int RW = LOG_ROB_ENTRIES;
  localparam int CW = $clog2(N+1);

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          upd_v = 1'b0;
  logic [IW-1:0] upd_info = '0;
  logic [RW-1:0] upd_idx = '0;
  logic          kv = 1'b0;
  logic [RW-1:0] kh = '0;
  logic [RW-1:0] kr = '0;
  logic          wv;
  logic [IW-1:0] winfo;
  logic [RW-1:0] widx;
  logic          rdy = 1'b0;
  logic          drop;
  logic [CW-1:0] cnt;

  ssu_rob_mdp_update_q dut (
    .CLK                             (CLK),
    .nRST                            (nRST),
    .rob_mdp_update_valid            (upd_v),
    .rob_mdp_update_mdp_info         (upd_info),
    .rob_mdp_update_ROB_index        (upd_idx),
    .rob_kill_valid                  (kv),
    .rob_kill_abs_head_index         (kh),
    .rob_kill_rel_kill_younger_index (kr),
    .rob_mdp_write_valid             (wv),
    .rob_mdp_write_mdp_info          (winfo),
    .rob_mdp_write_ROB_index         (widx),
    .rob_mdp_write_ready             (rdy),
    .mdp_update_drop                 (drop),
    .mdp_update_q_count              (cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int info;
    int idx;
  } ent_t;

  ent_t mq[$];
  int   mdrop;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("valid", 32'(wv), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("info", 32'(winfo), 32'(mq[0].info));
      chk("idx", 32'(widx), 32'(mq[0].idx));
    end
    chk("count", 32'(cnt), 32'(mq.size()));
    chk("drop", 32'(drop), 32'(mdrop));
  endtask

  function automatic bit is_killed(int idx, bit k,
                                   int head, int rel_k);
    int rel;
    rel = (idx - head + (1 << RW)) % (1 << RW);
    return k && (rel >= rel_k);
  endfunction

  // drive one cycle, advance model, check at negedge
  task automatic step(bit v, int info, int idx, bit k,
                      int head, int rel_k, bit r);
    ent_t nq[$];
    ent_t e;
    bit   merged;
    upd_v    = v;
    upd_info = IW'(info);
    upd_idx  = RW'(idx);
    kv       = k;
    kh       = RW'(head);
    kr       = RW'(rel_k);
    rdy      = r;
    for (int i = 0; i < mq.size(); i++) begin
      if (i == 0 && r) continue;
      if (is_killed(mq[i].idx, k, head, rel_k)) continue;
      nq.push_back(mq[i]);
    end
    mdrop  = 0;
    merged = 0;
    if (v && !is_killed(idx, k, head, rel_k)) begin
      foreach (nq[i]) begin
        if (nq[i].idx == idx) begin
          nq[i].info = info;
          merged = 1;
        end
      end
      if (!merged) begin
        if (nq.size() < N) begin
          e.info = info;
          e.idx  = idx;
          nq.push_back(e);
        end else begin
          mdrop = 1;
        end
      end
    end
    mq = nq;
    @(posedge CLK);
    @(negedge CLK);
    upd_v = 1'b0;
    kv    = 1'b0;
    check_all();
  endtask

  task automatic idle(bit r);
    step(0, 0, 0, 0, 0, 0, r);
  endtask

  task automatic drain();
    for (int i = 0; i < N + 1; i++) idle(1);
  endtask

  initial begin
    mdrop = 0;
    repeat (3) @(negedge CLK);
    chk("rst_valid", 32'(wv), 32'd0);
    chk("rst_info", 32'(winfo), 32'd0);
    chk("rst_idx", 32'(widx), 32'd0);
    chk("rst_drop", 32'(drop), 32'd0);
    chk("rst_count", 32'(cnt), 32'd0);
    nRST = 1'b1;
    @(negedge CLK);

    // latency-1 enqueue then dequeue
    step(1, 'h5A, 7, 0, 0, 0, 0);
    chk("lat_valid", 32'(wv), 32'd1);
    chk("lat_info", 32'(winfo), 32'h5A);
    chk("lat_idx", 32'(widx), 32'd7);
    idle(1);
    chk("lat_empty", 32'(wv), 32'd0);

    // coalesce
    step(1, 'h11, 3, 0, 0, 0, 0);
    step(1, 'h22, 9, 0, 0, 0, 0);
    step(1, 'h33, 3, 0, 0, 0, 0);
    chk("co_count", 32'(cnt), 32'd2);
    chk("co_info", 32'(winfo), 32'h33);
    idle(1);
    chk("co_idx2", 32'(widx), 32'd9);
    chk("co_info2", 32'(winfo), 32'h22);
    drain();

    // drop on full, then full with dequeue
    for (int i = 1; i <= 4; i++)
      step(1, 'h40 + i, i, 0, 0, 0, 0);
    step(1, 'h55, 5, 0, 0, 0, 0);
    chk("drop_pulse", 32'(drop), 32'd1);
    chk("drop_count", 32'(cnt), 32'd4);
    idle(0);
    chk("drop_clear", 32'(drop), 32'd0);
    step(1, 'h55, 5, 0, 0, 0, 1);
    chk("fd_nodrop", 32'(drop), 32'd0);
    chk("fd_count", 32'(cnt), 32'd4);
    drain();

    // flush with wrap, incoming killed too
    step(1, 'h62, 62, 0, 0, 0, 0);
    step(1, 'h01, 1, 0, 0, 0, 0);
    step(1, 'h05, 5, 0, 0, 0, 0);
    step(1, 'h77, 0, 1, 60, 4, 0);
    chk("kill_count", 32'(cnt), 32'd1);
    chk("kill_idx", 32'(widx), 32'd62);
    chk("kill_drop", 32'(drop), 32'd0);
    drain();

    // full plus unmatched incoming with ready
    for (int i = 1; i <= 4; i++)
      step(1, i, i, 0, 0, 0, 0);
    step(1, 'h88, 8, 0, 0, 0, 1);
    chk("full_rdy_cnt", 32'(cnt), 32'd4);
    chk("full_rdy_drop", 32'(drop), 32'd0);
    drain();

    // random traffic
    for (int t = 0; t < 3000; t++) begin
      step($urandom_range(0, 3) != 0,
           int'($urandom_range(0, 255)),
           int'($urandom_range(0, 11)),
           $urandom_range(0, 9) == 0,
           int'($urandom_range(0, 63)),
           int'($urandom_range(0, 63)),
           (t < 1500) ? ($urandom_range(0, 3) == 0)
                      : ($urandom_range(0, 2) != 0));
    end
    drain();

    // asynchronous reset mid-stream
    for (int i = 1; i <= 3; i++)
      step(1, 'h90 + i, 20 + i, 0, 0, 0, 0);
    chk("pre_rst_cnt", 32'(cnt), 32'd3);
    #2 nRST = 1'b0;
    #1;
    chk("arst_valid", 32'(wv), 32'd0);
    chk("arst_info", 32'(winfo), 32'd0);
    chk("arst_idx", 32'(widx), 32'd0);
    chk("arst_count", 32'(cnt), 32'd0);
    mq.delete();
    mdrop = 0;
    @(negedge CLK);
    nRST = 1'b1;
    idle(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule

// File: doc/ssu_rob_mdp_update_q.md
Name: ssu_rob_mdp_update_q

Overview:
- Sits directly downstream of the store set unit (ssu), between its mdp-update-to-rob output and the ROB's mdp write port.
- ssu emits updates without backpressure; the ROB write port can stall. This block buffers updates in a small compacting queue and drains them with valid/ready.
- Merges repeat updates to the same ROB entry, and discards updates to ROB entries killed by a flush.

Parameters:
- MDP_UPDATE_Q_ENTRIES, 4, queue depth; power of 2 not required, minimum 2.
- MDPT_INFO_WIDTH, core_types_pkg::MDPT_INFO_WIDTH, mdp info width.
- LOG_ROB_ENTRIES, core_types_pkg::LOG_ROB_ENTRIES, ROB index width.

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- rob_mdp_update_valid  in  1  update from ssu
- rob_mdp_update_mdp_info  in  MDPT_INFO_WIDTH  new mdp info
- rob_mdp_update_ROB_index  in  LOG_ROB_ENTRIES  target ROB entry
- rob_kill_valid  in  1  flush this cycle
- rob_kill_abs_head_index  in  LOG_ROB_ENTRIES  ROB head at flush
- rob_kill_rel_kill_younger_index  in  LOG_ROB_ENTRIES  relative index; entries at or beyond it are killed
- rob_mdp_write_valid  out  1  head entry valid
- rob_mdp_write_mdp_info  out  MDPT_INFO_WIDTH  head mdp info
- rob_mdp_write_ROB_index  out  LOG_ROB_ENTRIES  head ROB index
- rob_mdp_write_ready  in  1  ROB accepts write
- mdp_update_drop  out  1  registered pulse: an incoming update was dropped (queue full)
- mdp_update_q_count  out  $clog2(MDP_UPDATE_Q_ENTRIES+1)  registered occupancy

Behaviour:
- Interface: one clock, CLK; asynchronous active-low reset, nRST. All state resets immediately on nRST low.
- Reset values: all entry valid bits 0, so rob_mdp_write_valid=0. rob_mdp_write_mdp_info and rob_mdp_write_ROB_index are 0 (storage cleared). mdp_update_drop=0. mdp_update_q_count=0.
- Storage: compacting shift queue; slot 0 is the head. Outputs are driven directly from slot 0 registers, with zero combinational path from inputs.
- Dequeue: occurs when rob_mdp_write_valid & rob_mdp_write_ready. Slot 0 leaves and survivors shift down.
- Kill rule: relative index = (entry ROB_index - rob_kill_abs_head_index) mod 2^LOG_ROB_ENTRIES, computed in LOG_ROB_ENTRIES bits with natural wrap. The entry is killed when rob_kill_valid and rel >= rob_kill_rel_kill_younger_index.
  - Applies to every stored entry and to the same-cycle incoming update.
  - The killed slot-0 entry is still presented this cycle. If dequeued, the write has already happened and is harmless; if not dequeued, it is removed.
- Survivors: next-state queue = stored entries minus (dequeued head) minus (killed entries), compacted in original order. Then the incoming update is applied, if surviving.
- Coalesce: incoming ROB_index equal to a surviving, non-dequeued entry overwrites that entry's mdp_info in place. Position and count are unchanged.
  - At most one match exists, as the invariant keeps ROB_index values unique in the queue.
  - An incoming update matching only the dequeued head is appended, not merged.
- Append: no match and post-removal count < MDP_UPDATE_Q_ENTRIES: write at the first free slot.
- Drop: no match and post-removal count = MDP_UPDATE_Q_ENTRIES. The incoming update is discarded and mdp_update_drop = 1 the next cycle. This is safe, as mdp info is a prediction hint.
- Full with simultaneous dequeue: a slot frees, so append is allowed and there is no drop.
- Empty with incoming update: the update appears at rob_mdp_write_* the next cycle (latency 1).
- Incoming killed the same cycle: not enqueued, not merged, no drop pulse.
- Reset mid-operation: all queued updates are lost; the ROB re-learns from ssu.

Decomposition:
- core_types_pkg: MDPT_INFO_WIDTH and LOG_ROB_ENTRIES (existing); add MDP_UPDATE_Q_ENTRIES as a package constant next to SSU_FUNNEL_BUFFER_ENTRIES.
- Sub-module: rob_rel_kill_check, combinational. Inputs are an index plus the kill bundle; output is killed. It is instantiated per slot plus once for the incoming update, and is reusable by other LSQ blocks.
- The compaction is inline, a per-slot prefix-count mux.

Test Plan:
- Reset, then one update (info=0x5A, idx=7) with ready=0 -> next cycle write_valid=1, info 0x5A, idx 7, count=1; raise ready -> following cycle valid=0, count=0.
- ready=0; updates idx 3 (info 0x11), idx 9 (0x22), idx 3 (0x33) -> count=2, head idx3 info 0x33, then idx9 0x22.
- ready=0; fill 4 entries idx 1,2,3,4, send idx 5 -> mdp_update_drop=1 one cycle, count stays 4, idx5 never output. Repeat idx 5 send with ready=1 -> no drop, idx5 appended at tail.
- Queue holds idx 62,1,5 (LOG_ROB_ENTRIES=6), kill with head=60, rel_kill=4 -> rel 2,5,9; only idx62 survives, count=1. Same-cycle incoming idx 0 (rel 4) is discarded, no drop.
- ready=1, full queue plus incoming idx 8 matching nothing -> head dequeued, idx8 appended, count stays 4, no drop.
- Assert nRST mid-stream with count=3 -> outputs 0 immediately (asynchronously), count=0 after release.
